// File: rtl/mcp3008_pkg.sv
// Shared types and frame constants for the MCP3008 SPI reader.
// MOSI frame helper: start bit, SGL/DIFF, D2..D0, then zeros.
package mcp3008_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MCP_FRAME_LEN = 17;
  localparam int MCP_NULL_EDGE = 7;
  localparam int MCP_DATA_W    = 10;
  localparam int MCP_CH_W      = 3;

  // Bit driven on DIN while SCLK period 'period' is active.
  function automatic logic mosi_bit(input logic [4:0] period, input logic sgl,
                                    input logic [MCP_CH_W-1:0] ch);
    logic b;
    b = 1'b0;
    case (period)
      5'd1:    b = 1'b1;
      5'd2:    b = sgl;
      5'd3:    b = ch[2];
      5'd4:    b = ch[1];
      5'd5:    b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mcp3008_reader_spi_clk_gen.sv
// SCLK generator: CLK_DIV-cycle half periods while i_run is high, idling low.
// o_rise/o_fall flag the cycle in which SCLK is about to be driven high/low.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_stop,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick = i_run && (r_cnt == DW'(CLK_DIV - 1));
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_run) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      // The closing low half of the frame ends without another rising edge.
      r_sclk <= r_sclk ? 1'b0 : !i_stop;
    end else begin
      r_cnt <= r_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/mcp3008_reader.sv
// MCP3008 SPI initiator: one conversion per accepted start, registered result.
// Define MCP3008_AUTOSCAN_EN to take the channel from an internal 0..7 scan counter.
module mcp3008_reader
  import mcp3008_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned CS_IDLE = 16
) (
  input  logic                  clk_50M,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MCP_CH_W-1:0]   ch_sel,
  input  logic                  sgl_diff,
  input  logic                  spi_miso,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  output logic [MCP_DATA_W-1:0] out_data,
  output logic [MCP_CH_W-1:0]   channel,
  output logic                  data_valid,
  output logic                  null_err,
  output logic                  busy
);

  localparam int CSW = $clog2(CS_IDLE + 1);

  state_t                r_state, w_next;
  logic [CSW-1:0]        r_cs_cnt;
  logic [4:0]            r_period;
  logic [MCP_DATA_W-1:0] r_shift;
  logic                  r_null;
  logic [MCP_CH_W-1:0]   r_ch;
  logic                  r_sgl;
  logic                  w_run, w_rise, w_fall, w_last, w_accept, w_done_entry;
  logic [MCP_CH_W-1:0]   w_ch_src;

`ifdef MCP3008_AUTOSCAN_EN
  logic [MCP_CH_W-1:0] r_scan;
  assign w_ch_src = r_scan;
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst)              r_scan <= '0;
    else if (w_done_entry) r_scan <= r_scan + MCP_CH_W'(1);
  end
`else
  assign w_ch_src = ch_sel;
`endif

  assign w_run        = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
  assign w_last       = (r_period == 5'(MCP_FRAME_LEN));
  assign w_accept     = (r_state == ST_IDLE) && start && (r_cs_cnt == '0);
  assign w_done_entry = (r_state == ST_SHIFT) && w_rise && w_last;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk   (clk_50M),
    .i_rst_n (rst),
    .i_run   (w_run),
    .i_stop  (w_last),
    .o_sclk  (spi_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SETUP;
      ST_SETUP: if (w_rise) w_next = ST_SHIFT;
      ST_SHIFT: if (w_rise && w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      r_cs_cnt   <= CSW'(CS_IDLE);
      r_period   <= '0;
      r_shift    <= '0;
      r_null     <= 1'b0;
      r_ch       <= '0;
      r_sgl      <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_mosi   <= 1'b0;
      out_data   <= '0;
      channel    <= '0;
      data_valid <= 1'b0;
      null_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      null_err   <= 1'b0;
      if (!w_run && r_cs_cnt != '0) r_cs_cnt <= r_cs_cnt - CSW'(1);
      if (w_accept) begin
        r_ch     <= w_ch_src;
        r_sgl    <= sgl_diff;
        busy     <= 1'b1;
        spi_cs_n <= 1'b0;
        spi_mosi <= 1'b1;
      end
      if (w_fall) spi_mosi <= mosi_bit(r_period + 5'd1, r_sgl, r_ch);
      if (w_rise && !w_last) r_period <= r_period + 5'd1;
      // r_period holds the period before this rise, so edge n sees n-1.
      if (w_rise && r_state == ST_SHIFT) begin
        if (r_period == 5'(MCP_NULL_EDGE - 1))
          r_null <= spi_miso;
        else if (r_period >= 5'(MCP_NULL_EDGE) && !w_last)
          r_shift <= {r_shift[MCP_DATA_W-2:0], spi_miso};
      end
      if (w_done_entry) begin
        spi_cs_n <= 1'b1;
        spi_mosi <= 1'b0;
        busy     <= 1'b0;
        r_period <= '0;
        r_cs_cnt <= CSW'(CS_IDLE);
        if (!r_null) begin
          out_data   <= r_shift;
          channel    <= r_ch;
          data_valid <= 1'b1;
        end else begin
          null_err <= 1'b1;
        end
      end
    end
  end

endmodule
